// File: rtl/ram_seq_ctrl.sv
// Block-operation sequencer (FILL / COPY / SUM) for a 64x8 scratch RAM whose single
// write port is shared with a host; host writes always win and stall the engine.
module ram_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        OP_FILL = 2'b00,
        OP_COPY = 2'b01,
        OP_SUM  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_COPY_RD,
        S_COPY_WR,
        S_SUM,
        S_DONE
    } state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_stage;
    logic [DATA_W-1:0] r_result;
    logic              r_err;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_src_addr;
    logic [ADDR_W-1:0] w_dst_addr;
    logic [DATA_W-1:0] w_src_data;
    logic              w_last;
    logic              w_eng_we;
    logic [DATA_W-1:0] w_eng_wdata;

    // Offsets are truncated to ADDR_W bits so block ranges wrap around the array.
    assign w_src_addr  = r_src + r_cnt[ADDR_W-1:0];
    assign w_dst_addr  = r_dst + r_cnt[ADDR_W-1:0];
    assign w_src_data  = r_mem[w_src_addr];
    assign w_last      = (r_cnt + (ADDR_W+1)'(1)) == r_len;
    assign w_eng_we    = ((r_state == S_FILL) || (r_state == S_COPY_WR)) && !host_we;
    assign w_eng_wdata = (r_state == S_FILL) ? r_fill : r_stage;

    assign host_rdata = r_mem[host_addr];
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign result     = r_result;

    // NOTE: the RAM has no reset branch; its contents must survive rst, and leaving
    // it out keeps the array mappable onto a plain memory macro.
    always_ff @(posedge clk) begin
        if (host_we)
            r_mem[host_addr] <= host_wdata;
        else if (w_eng_we)
            r_mem[w_dst_addr] <= w_eng_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read of a
    // register (or of r_mem) in this block sees its value from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_fill   <= '0;
            r_stage  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src  <= src;
                        r_dst  <= dst;
                        r_len  <= len;
                        r_fill <= fill_val;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                        if (op_e'(op) == OP_SUM)
                            r_result <= '0;
                        if (op_e'(op) == OP_RSVD || len > MAX_LEN) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_busy <= 1'b1;
                            case (op_e'(op))
                                OP_FILL: r_state <= S_FILL;
                                OP_COPY: r_state <= S_COPY_RD;
                                default: r_state <= S_SUM;
                            endcase
                        end
                    end
                end
                S_FILL: begin
                    if (!host_we) begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + (ADDR_W+1)'(1);
                        end
                    end
                end
                S_COPY_RD: begin
                    r_stage <= w_src_data;
                    r_state <= S_COPY_WR;
                end
                S_COPY_WR: begin
                    if (!host_we) begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + (ADDR_W+1)'(1);
                            r_state <= S_COPY_RD;
                        end
                    end
                end
                S_SUM: begin
                    r_result <= r_result + w_src_data;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + (ADDR_W+1)'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
